// File: rtl/mult_div_pkg.sv
// mult_div_pkg
//   Shared constants and types for the iterative multiplier/divider:
//   data width, iteration counts, FSM state encodings, Booth recoding.
package mult_div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam logic [CNT_W-1:0] MULT_ITERS = 6'd16;  // radix-4: two bits per step
  localparam logic [CNT_W-1:0] DIV_ITERS  = 6'd32;  // one quotient bit per step

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Plain vector constants so the state register stays a simple logic [1:0].
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_MULT = ST_MULT;
  localparam logic [1:0] S_DIV  = ST_DIV;
  localparam logic [1:0] S_DONE = ST_DONE;

  // Radix-4 Booth digit selected by {Q[1], Q[0], Q[-1]}.
  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_P1   = 3'd1,
    BOOTH_P2   = 3'd2,
    BOOTH_M1   = 3'd3,
    BOOTH_M2   = 3'd4
  } booth_op_e;

  function automatic booth_op_e booth_decode(input logic [2:0] bits);
    booth_op_e op;
    case (bits)
      3'b001, 3'b010: op = BOOTH_P1;
      3'b011:         op = BOOTH_P2;
      3'b100:         op = BOOTH_M2;
      3'b101, 3'b110: op = BOOTH_M1;
      default:        op = BOOTH_ZERO;   // 000 and 111
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// mult_div_if
//   Operand/control/result bundle between the execute stage and mult_div.
//   master: drives operand_a, operand_b, ctrl_mult, ctrl_div;
//           receives result, except, ready, qaq, faq.
//   slave : the opposite directions (used by mult_div).
interface mult_div_if
  import mult_div_pkg::*;
();

  logic [WIDTH-1:0]   operand_a;
  logic [WIDTH-1:0]   operand_b;
  logic               ctrl_mult;
  logic               ctrl_div;
  logic [WIDTH-1:0]   result;
  logic               except;
  logic               ready;
  logic [2*WIDTH-1:0] qaq;
  logic [2*WIDTH-1:0] faq;

  modport master (
    output operand_a, operand_b, ctrl_mult, ctrl_div,
    input  result, except, ready, qaq, faq
  );

  modport slave (
    input  operand_a, operand_b, ctrl_mult, ctrl_div,
    output result, except, ready, qaq, faq
  );

endinterface

// File: rtl/mult_div_addsub.sv
// mult_div_addsub
//   Combinational add/subtract unit shared by the Booth step and the
//   non-restoring divide step.
//   a, b : W-bit two's complement operands
//   sub  : 1 = a - b (b inverted), 0 = a + b
//   cin  : carry-in; tie to sub for a true subtract
//   sum  : W-bit result (wraps; callers size W so it never overflows)
module mult_div_addsub #(
  parameter int W = 34
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [W-1:0] sum
);

  logic [W-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + {{(W-1){1'b0}}, cin};

endmodule

// File: rtl/mult_div.sv
// mult_div
//   Iterative signed 32-bit multiplier (radix-4 Booth, 16 steps) and
//   divider (non-restoring on magnitudes, 32 steps + 1 sign-fixup step).
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : mult_div_if.slave
//           operand_a/operand_b sampled when ctrl_mult/ctrl_div is high
//           result/except/faq valid from the ready pulse until next start
//           qaq shows the live working register, faq the final register
module mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = mult_div_pkg::WIDTH
) (
  input  logic clock,
  input  logic reset,
  mult_div_if.slave bus
);

  localparam int XW = WIDTH + 2;   // adder width: covers +/-2M and 2R+1

  logic [1:0]         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [XW-1:0]      acc_hi_q, acc_hi_d;   // Booth A / divider remainder
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;   // Booth Q / divider quotient
  logic               qm1_q,    qm1_d;      // Booth Q[-1]
  logic [WIDTH-1:0]   opnd_q,   opnd_d;     // multiplicand / divisor magnitude
  logic               q_neg_q,  q_neg_d;
  logic               r_neg_q,  r_neg_d;
  logic               dz_q,     dz_d;
  logic               dexc_q,   dexc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               except_q, except_d;
  logic               ready_q,  ready_d;
  logic [2*WIDTH-1:0] faq_q,    faq_d;

  logic [XW-1:0]      add_a, add_b, add_sum;
  logic               add_sub;
  booth_op_e          booth_op;
  logic [XW-1:0]      mcand_x1, mcand_x2, divisor_x;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [XW-1:0]      rem_mag;

  assign booth_op  = booth_decode({acc_lo_q[1:0], qm1_q});
  assign mcand_x1  = {{2{opnd_q[WIDTH-1]}}, opnd_q};
  assign mcand_x2  = {opnd_q[WIDTH-1], opnd_q, 1'b0};
  assign divisor_x = {2'b00, opnd_q};
  assign product   = {acc_hi_q[WIDTH-1:0], acc_lo_q};
  assign a_mag     = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
  assign b_mag     = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;

  mult_div_addsub #(.W(XW)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .cin (add_sub),
    .sum (add_sum)
  );

  // Adder operand steering
  always_comb begin
    add_a   = acc_hi_q;
    add_b   = '0;
    add_sub = 1'b0;
    case (state_q)
      S_MULT: begin
        case (booth_op)
          BOOTH_P1: add_b = mcand_x1;
          BOOTH_P2: add_b = mcand_x2;
          BOOTH_M1: begin add_b = mcand_x1; add_sub = 1'b1; end
          BOOTH_M2: begin add_b = mcand_x2; add_sub = 1'b1; end
          default:  add_b = '0;
        endcase
      end
      S_DIV: begin
        add_b = divisor_x;
        if (cnt_q < DIV_ITERS) begin
          // Shift the next dividend bit into the remainder; subtract the
          // divisor while the partial remainder is non-negative, else add.
          add_a   = {acc_hi_q[XW-2:0], acc_lo_q[WIDTH-1]};
          add_sub = ~acc_hi_q[XW-1];
        end else begin
          // Fixup step: restore a negative final remainder by adding D.
          add_a   = acc_hi_q;
          add_sub = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    qm1_d    = qm1_q;
    opnd_d   = opnd_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dz_d     = dz_q;
    dexc_d   = dexc_q;
    result_d = result_q;
    except_d = except_q;
    faq_d    = faq_q;
    ready_d  = 1'b0;
    rem_mag  = acc_hi_q;

    if (bus.ctrl_mult || bus.ctrl_div) begin
      // A start from any state abandons whatever was in flight.
      cnt_d    = '0;
      acc_hi_d = '0;
      qm1_d    = 1'b0;
      result_d = '0;
      except_d = 1'b0;
      faq_d    = '0;
      if (bus.ctrl_mult) begin
        state_d  = S_MULT;
        acc_lo_d = bus.operand_b;
        opnd_d   = bus.operand_a;
      end else begin
        state_d  = S_DIV;
        acc_lo_d = a_mag;
        opnd_d   = b_mag;
        q_neg_d  = bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
        r_neg_d  = bus.operand_a[WIDTH-1];
        dz_d     = (bus.operand_b == '0);
        dexc_d   = (bus.operand_b == '0) ||
                   ((bus.operand_a == INT_MIN) && (bus.operand_b == '1));
      end
    end else begin
      case (state_q)
        S_MULT: begin
          if (cnt_q < MULT_ITERS) begin
            // Arithmetic shift of {A, Q, Q[-1]} right by two.
            acc_hi_d = {{2{add_sum[XW-1]}}, add_sum[XW-1:2]};
            acc_lo_d = {add_sum[1:0], acc_lo_q[WIDTH-1:2]};
            qm1_d    = acc_lo_q[1];
            cnt_d    = cnt_q + 6'd1;
          end else begin
            result_d = acc_lo_q;
            // Product fits in 32 signed bits only if bits 63..31 agree.
            except_d = ~((&product[2*WIDTH-1:WIDTH-1]) |
                         ~(|product[2*WIDTH-1:WIDTH-1]));
            faq_d    = product;
            ready_d  = 1'b1;
            state_d  = S_DONE;
          end
        end
        S_DIV: begin
          if (cnt_q < DIV_ITERS) begin
            acc_hi_d = add_sum;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], ~add_sum[XW-1]};
            cnt_d    = cnt_q + 6'd1;
          end else if (cnt_q == DIV_ITERS) begin
            rem_mag  = acc_hi_q[XW-1] ? add_sum : acc_hi_q;
            acc_hi_d = r_neg_q ? -rem_mag : rem_mag;
            acc_lo_d = q_neg_q ? -acc_lo_q : acc_lo_q;
            cnt_d    = cnt_q + 6'd1;
          end else begin
            // Divide by zero leaves an all-ones quotient; report 0 instead.
            result_d = dz_q ? '0 : acc_lo_q;
            except_d = dexc_q;
            faq_d    = {acc_hi_q[WIDTH-1:0], dz_q ? '0 : acc_lo_q};
            ready_d  = 1'b1;
            state_d  = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      qm1_q    <= 1'b0;
      opnd_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      dexc_q   <= 1'b0;
      result_q <= '0;
      except_q <= 1'b0;
      ready_q  <= 1'b0;
      faq_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      qm1_q    <= qm1_d;
      opnd_q   <= opnd_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dz_q     <= dz_d;
      dexc_q   <= dexc_d;
      result_q <= result_d;
      except_q <= except_d;
      ready_q  <= ready_d;
      faq_q    <= faq_d;
    end
  end

  assign bus.result = result_q;
  assign bus.except = except_q;
  assign bus.ready  = ready_q;
  assign bus.qaq    = {acc_hi_q[WIDTH-1:0], acc_lo_q};
  assign bus.faq    = faq_q;

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div
//   Scoreboard bench for mult_div: each start pushes the expected result,
//   exception, final register and latency; the ready monitor pops and
//   compares. Prints one line per completed transaction.
module tb_mult_div;
  import mult_div_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        exc;
    logic [63:0] faq;
    bit          chk_faq;
    int          lat;
    int          e0;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] last_res = '0;
  exp_t sb_q[$];

  mult_div_if bus();

  mult_div dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Completion monitor
  always @(negedge clock) begin : mon
    exp_t e;
    if (!reset && bus.ready) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_ready", 64'(bus.ready), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_val({e.name, "_result"}, 64'(bus.result), 64'(e.res));
        check_val({e.name, "_except"}, 64'(bus.except), 64'(e.exc));
        if (e.chk_faq) check_val({e.name, "_faq"}, bus.faq, e.faq);
        check_val({e.name, "_latency"}, 64'(cyc - e.e0), 64'(e.lat));
        last_res = e.res;
        $display("txn %-14s a/b done res=%h exc=%0d lat=%0d", e.name, bus.result, bus.except, cyc - e.e0);
      end
    end
  end

  task automatic start_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b, input string name);
    exp_t   e;
    longint pa, pb, p;
    int     sa, sb, q, r;
    @(negedge clock);
    bus.operand_a = a;
    bus.operand_b = b;
    bus.ctrl_mult = is_mult;
    bus.ctrl_div  = !is_mult;
    e.name    = name;
    e.e0      = cyc + 1;
    e.chk_faq = 1'b1;
    if (is_mult) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      p  = pa * pb;
      e.res = p[31:0];
      e.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      e.faq = p;
      e.lat = 17;
    end else begin
      sa = int'(a);
      sb = int'(b);
      e.lat = 34;
      if (sb == 0) begin
        e.res = 32'd0; e.exc = 1'b1; e.faq = '0; e.chk_faq = 1'b0;
      end else if (a == INT_MIN && sb == -1) begin
        e.res = INT_MIN; e.exc = 1'b1; e.faq = '0; e.chk_faq = 1'b0;
      end else begin
        q = sa / sb;
        r = sa % sb;
        e.res = q; e.exc = 1'b0; e.faq = {r, q};
      end
    end
    sb_q.delete();   // any in-flight operation is aborted
    sb_q.push_back(e);
    @(negedge clock);
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    check_val({name, "_clr_result"}, 64'(bus.result), 64'd0);
    check_val({name, "_clr_faq"}, bus.faq, 64'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (sb_q.size() != 0) begin
      check_val("timeout_pending", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  task automatic run_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b, input string name);
    start_op(is_mult, a, b, name);
    wait_done();
    repeat (3) @(negedge clock);
    check_val({name, "_hold"}, 64'(bus.result), 64'(last_res));
    check_val({name, "_ready_low"}, 64'(bus.ready), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    repeat (3) @(negedge clock);
    check_val("rst_result", 64'(bus.result), 64'd0);
    check_val("rst_except", 64'(bus.except), 64'd0);
    check_val("rst_ready", 64'(bus.ready), 64'd0);
    check_val("rst_qaq", bus.qaq, 64'd0);
    check_val("rst_faq", bus.faq, 64'd0);
    reset = 1'b0;

    run_op(1'b1, 32'd7, 32'hFFFF_FFFA, "mul_7x-6");
    run_op(1'b1, 32'd65536, 32'd65536, "mul_ovf");
    run_op(1'b1, 32'h8000_0000, 32'd1, "mul_intmin");
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, "mul_min2");
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, "div_-7/2");
    run_op(1'b0, 32'd7, 32'hFFFF_FFFE, "div_7/-2");
    run_op(1'b0, 32'd100, 32'd7, "div_100/7");
    run_op(1'b0, 32'd5, 32'd0, "div_by0");
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "div_min/-1");
    run_op(1'b0, 32'h8000_0000, 32'd3, "div_min/3");

    // Restart: multiply aborted by a divide pulse five cycles later
    start_op(1'b1, 32'd123, 32'd456, "mul_aborted");
    repeat (3) @(negedge clock);
    start_op(1'b0, 32'd100, 32'd10, "div_restart");
    wait_done();

    // Reset in the middle of a divide
    start_op(1'b0, 32'd1000, 32'd3, "div_reset");
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    sb_q.delete();
    #1;
    check_val("midrst_result", 64'(bus.result), 64'd0);
    check_val("midrst_except", 64'(bus.except), 64'd0);
    check_val("midrst_qaq", bus.qaq, 64'd0);
    check_val("midrst_faq", bus.faq, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (45) @(negedge clock);   // monitor flags any ready here
    check_val("post_rst_qaq", bus.qaq, 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(i[0], $urandom, $urandom >> $urandom_range(0, 28), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
